// File: rtl/dcache_pkg.sv
// dcache_pkg: cache geometry, FSM state type and address-field helpers.
// Shared by dcache_ctrl and dcache_data_ram.
package dcache_pkg;

  localparam int LINES  = 16;
  localparam int WORDS  = 4;
  localparam int ADDR_W = 32;

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W - 2;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    REFILL
  } dcache_state_t;

  function automatic logic [OFF_W-1:0] addr_off(
    input logic [ADDR_W-1:0] a
  );
    return a[OFF_W+1:2];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(
    input logic [ADDR_W-1:0] a
  );
    return a[IDX_W+OFF_W+1:OFF_W+2];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(
    input logic [ADDR_W-1:0] a
  );
    return a[ADDR_W-1:ADDR_W-TAG_W];
  endfunction

  function automatic logic [ADDR_W-1:0] line_addr(
    input logic [TAG_W-1:0] t,
    input logic [IDX_W-1:0] i,
    input logic [OFF_W-1:0] o
  );
    return {t, i, o, 2'b00};
  endfunction

endpackage

// File: rtl/dcache_data_ram.sv
// dcache_data_ram: LINES x WORDS x 32 data store.
// Combinational read, synchronous write.
module dcache_data_ram #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(LINES)-1:0] idx,
  input  logic [$clog2(WORDS)-1:0] woff,
  input  logic [$clog2(WORDS)-1:0] roff,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [LINES][WORDS];

  // single write port; data arrays need no reset
  always_ff @(posedge clk) begin
    if (we) mem[idx][woff] <= wdata;
  end

  assign rdata = mem[idx][roff];

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate D-cache.
// Optional hit/miss counters when DCACHE_STATS_EN is defined.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES  = dcache_pkg::LINES,
  parameter int WORDS  = dcache_pkg::WORDS,
  parameter int ADDR_W = dcache_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              dhit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  dcache_state_t state, next;

  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;
  logic [OFF_W-1:0] cnt;

  logic [LINES-1:0] valid, dirty;
  logic [TAG_W-1:0] tags [LINES];

  logic hit, last, st_hit, miss;
  logic ram_we;
  logic [OFF_W-1:0] ram_woff, ram_roff;
  logic [31:0] ram_wdata, ram_rdata;
  logic unused_bits;

  assign tag = addr_tag(cpu_addr);
  assign idx = addr_idx(cpu_addr);
  assign off = addr_off(cpu_addr);
  assign unused_bits = ^cpu_addr[1:0];

  assign hit    = valid[idx] && (tags[idx] == tag);
  assign last   = &cnt;
  assign dhit   = !cpu_req || (state == IDLE && hit);
  assign st_hit = state == IDLE && cpu_req && cpu_we && hit;
  assign miss   = state == IDLE && next != IDLE;

  assign cpu_rdata =
    (cpu_req && state == IDLE && hit) ? ram_rdata : '0;

  // store-hit and refill share the RAM write port
  always_comb begin
    ram_we    = st_hit || (state == REFILL && mem_ready);
    ram_woff  = (state == REFILL) ? cnt : off;
    ram_wdata = (state == REFILL) ? mem_rdata : cpu_wdata;
    ram_roff  = (state == WB) ? cnt : off;
  end

  dcache_data_ram #(
    .LINES(LINES),
    .WORDS(WORDS)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .idx  (idx),
    .woff (ram_woff),
    .roff (ram_roff),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  // next-state logic
  always_comb begin
    next = state;
    case (state)
      IDLE:
        if (cpu_req && !hit)
          next = (valid[idx] && dirty[idx]) ? WB : REFILL;
      WB:
        if (mem_ready && last) next = REFILL;
      REFILL:
        if (mem_ready && last) next = IDLE;
      default:
        next = IDLE;
    endcase
  end

  // memory-port outputs decoded from state
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = line_addr(tags[idx], idx, cnt);
        mem_wdata = ram_rdata;
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = line_addr(tag, idx, cnt);
      end
      default: ;
    endcase
  end

  // burst word counter, wraps to 0 at each burst end
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (state != IDLE && mem_ready)
      cnt <= cnt + 1'b1;
  end

  // valid/dirty; a line being replaced is invalid until refilled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      if (st_hit) dirty[idx] <= 1'b1;
      if (miss) valid[idx] <= 1'b0;
      if (state == WB && mem_ready && last)
        dirty[idx] <= 1'b0;
      if (state == REFILL && mem_ready && last)
        valid[idx] <= 1'b1;
    end
  end

  // tag written when the refill completes
  always_ff @(posedge clk) begin
    if (state == REFILL && mem_ready && last)
      tags[idx] <= tag;
  end

`ifdef DCACHE_STATS_EN
  // saturating hit and miss counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (cpu_req && dhit && !(&hit_cnt))
        hit_cnt <= hit_cnt + 32'd1;
      if (miss && !(&miss_cnt))
        miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench for dcache_ctrl.
// Memory model answers bursts; expected transfers queued up front.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dhit, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .dhit     (dhit),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        sq[$];
  logic [31:0] rq[$];

  logic [31:0] mem   [logic [31:0]];
  logic [31:0] cview [logic [31:0]];
  bit          mvalid [16];
  bit          mdirty [16];
  logic [23:0] mtag   [16];

  int checks = 0;
  int errs = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {16'hA5A5 ^ a[31:16], a[15:0]};
  endfunction

  function automatic logic [31:0] cv_rd(input logic [31:0] a);
    if (cview.exists(a)) return cview[a];
    return mem_rd(a);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      mvalid[i] = 0;
      mdirty[i] = 0;
    end
    cview.delete();
    sq.delete();
    rq.delete();
    exp_hits = 0;
    exp_misses = 0;
  endtask

  // one CPU access with memory service; optional refill stall and flush
  task automatic access(input bit we, input logic [31:0] a,
                        input logic [31:0] wd, input int stall_word,
                        input int stall_n, input int flush_at);
    logic [3:0]  ix;
    logic [23:0] tg;
    logic [31:0] ea, exp;
    bit          hit, wb, done, flushed;
    int          pen, exp_pen, rd_i, stall_left;
    txn_t        t;
    ix = a[7:4];
    tg = a[31:8];
    hit = mvalid[ix] && mtag[ix] == tg;
    wb = !hit && mvalid[ix] && mdirty[ix];
    if (!hit) begin
      if (wb)
        for (int w = 0; w < 4; w++) begin
          ea = {mtag[ix], ix, 2'(w), 2'b00};
          sq.push_back('{1'b1, ea, cv_rd(ea)});
        end
      for (int w = 0; w < 4; w++) begin
        ea = {tg, ix, 2'(w), 2'b00};
        sq.push_back('{1'b0, ea, mem_rd(ea)});
      end
      exp_misses++;
    end
    if (!we && flush_at < 0) rq.push_back(cv_rd({a[31:2], 2'b00}));
    exp_pen = hit ? 0 : 1 + (wb ? 8 : 4) + stall_n;
    @(posedge clk);
    #1;
    cpu_req = 1;
    cpu_we = we;
    cpu_addr = a;
    cpu_wdata = wd;
    pen = 0;
    rd_i = 0;
    stall_left = stall_n;
    done = 0;
    flushed = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      mem_ready = 0;
      if (cpu_req && dhit) begin
        if (!we) begin
          exp = rq.pop_front();
          checks++;
          if (cpu_rdata !== exp) begin
            errs++;
            $display("FAIL rdata @%h: got %h want %h", a, cpu_rdata, exp);
          end
        end
        checks++;
        if (pen != exp_pen || mem_req !== 1'b0) begin
          errs++;
          $display("FAIL penalty @%h: got %0d req=%b want %0d req=0",
                   a, pen, mem_req, exp_pen);
        end
        exp_hits++;
        done = 1;
      end else if (!cpu_req && !mem_req) begin
        done = 1;
      end else begin
        if (cpu_req) pen++;
        if (mem_req) begin
          if (!mem_we && rd_i == stall_word && stall_left > 0) begin
            stall_left--;
            checks++;
            if (sq.size() == 0 || mem_addr !== sq[0].addr ||
                dhit !== 1'b0) begin
              errs++;
              $display("FAIL stall: addr %h dhit %b want addr %h dhit 0",
                       mem_addr, dhit, sq.size() ? sq[0].addr : 32'h0);
            end
          end else if (sq.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL xfer: unexpected we=%b addr %h want none",
                     mem_we, mem_addr);
            mem_ready = 1;
          end else begin
            t = sq.pop_front();
            checks++;
            if (mem_we !== t.we || mem_addr !== t.addr ||
                (t.we && mem_wdata !== t.data)) begin
              errs++;
              $display("FAIL xfer: got we=%b %h %h want we=%b %h %h",
                       mem_we, mem_addr, mem_wdata, t.we, t.addr, t.data);
            end
            if (t.we) mem[t.addr] = t.data;
            else begin
              mem_rdata = t.data;
              rd_i++;
            end
            mem_ready = 1;
          end
        end
        if (flush_at >= 0 && pen == flush_at && !flushed) begin
          cpu_req = 0;
          flushed = 1;
        end
      end
    end
    checks++;
    if (!done || sq.size() != 0) begin
      errs++;
      $display("FAIL done @%h: done=%b left=%0d want done=1 left=0",
               a, done, sq.size());
    end
    @(posedge clk);
    #1;
    cpu_req = 0;
    mem_ready = 0;
    if (!hit) begin
      mvalid[ix] = 1;
      mtag[ix] = tg;
      mdirty[ix] = 0;
    end
    if (we) begin
      cview[{a[31:2], 2'b00}] = wd;
      mdirty[ix] = 1;
    end
    sq.delete();
  endtask

  task automatic test_reset();
    reset = 1;
    cpu_req = 0;
    cpu_we = 0;
    cpu_addr = 0;
    cpu_wdata = 0;
    mem_ready = 0;
    mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    model_clear();
    @(negedge clk);
    checks++;
    if (dhit !== 1'b1 || cpu_rdata !== 32'h0 || mem_req !== 1'b0 ||
        mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errs++;
      $display("FAIL reset: dhit=%b rd=%h req=%b we=%b a=%h wd=%h want 1,0,0,0,0,0",
               dhit, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_refill();
    access(0, 32'h100, 0, -1, 0, -1);
  endtask

  task automatic test_store_hit();
    access(1, 32'h104, 32'hDEADBEEF, -1, 0, -1);
    access(0, 32'h104, 0, -1, 0, -1);
  endtask

  task automatic test_writeback();
    access(0, 32'h504, 0, -1, 0, -1);
    checks++;
    if (mem_rd(32'h104) !== 32'hDEADBEEF) begin
      errs++;
      $display("FAIL wb_data: got %h want deadbeef", mem_rd(32'h104));
    end
  endtask

  task automatic test_stats();
`ifdef DCACHE_STATS_EN
    checks++;
    if (hit_cnt !== 32'(exp_hits) || miss_cnt !== 32'(exp_misses)) begin
      errs++;
      $display("FAIL stats: hit=%0d miss=%0d want hit=%0d miss=%0d",
               hit_cnt, miss_cnt, exp_hits, exp_misses);
    end
`endif
  endtask

  task automatic test_stall();
    access(0, 32'h608, 0, 1, 3, -1);
  endtask

  task automatic test_flush();
    access(0, 32'h700, 0, -1, 0, 2);
    access(0, 32'h70C, 0, -1, 0, -1);
  endtask

  task automatic test_reset_mid_burst();
    int  rd_n;
    bit  seen;
    @(posedge clk);
    #1;
    cpu_req = 1;
    cpu_we = 0;
    cpu_addr = 32'h300;
    rd_n = 0;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      mem_ready = 0;
      if (mem_req) begin
        if (!mem_we && rd_n == 2) begin
          reset = 1;
          seen = 1;
        end else begin
          mem_ready = 1;
          mem_rdata = 32'hBAD0_0000 + 32'(rd_n);
          if (!mem_we) rd_n++;
        end
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (!seen || mem_req !== 1'b0) begin
      errs++;
      $display("FAIL reset_burst: seen=%b req=%b want seen=1 req=0",
               seen, mem_req);
    end
    reset = 0;
    cpu_req = 0;
    model_clear();
    access(0, 32'h300, 0, -1, 0, -1);
  endtask

  task automatic test_back_to_back();
    access(1, 32'h1010, 32'h1111_0001, -1, 0, -1);
    access(1, 32'h2014, 32'h2222_0002, -1, 0, -1);
    access(0, 32'h1010, 0, -1, 0, -1);
    access(0, 32'h2014, 0, -1, 0, -1);
    access(1, 32'h1018, 32'h3333_0003, -1, 0, -1);
    access(0, 32'h1018, 0, -1, 0, -1);
  endtask

  task automatic test_idle_ready();
    mem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || dhit !== 1'b1) begin
        errs++;
        $display("FAIL idle_ready: req=%b dhit=%b want 0 1", mem_req, dhit);
      end
    end
    @(posedge clk);
    #1;
    mem_ready = 0;
    access(0, 32'h1018, 0, -1, 0, -1);
  endtask

  initial begin
    test_reset();
    test_refill();
    test_store_hit();
    test_writeback();
    test_stats();
    test_stall();
    test_flush();
    test_reset_mid_burst();
    test_back_to_back();
    test_idle_ready();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
